// File: rtl/md_unit.sv
// Multiply/divide unit holding HI/LO beside the execute-stage ALU.
// Multi-cycle MULT/MULTU/DIV/DIVU with flush, single-cycle MTHI/MTLO.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] pend_hi, pend_lo;
    logic             pend_dz;

    logic             is_md, start, done, is_div, b_zero;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0] da, db, uq, ur, sq, sr;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign is_md  = (op >= OP_MULT) && (op <= OP_DIVU);
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign b_zero = (b == '0);
    assign start  = (state == IDLE) && is_md && !flush;
    assign done   = (state == RUN) && (cnt == CNT_W'(1));

    // One shared unsigned divider; signed DIV runs on magnitudes.
    always_comb begin
        prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        da = a;
        db = b;
        if (op == OP_DIV) begin
            da = a[WIDTH-1] ? -a : a;
            db = b[WIDTH-1] ? -b : b;
        end
        uq = b_zero ? '0 : da / db;
        ur = b_zero ? '0 : da % db;
        sq = (a[WIDTH-1] ^ b[WIDTH-1]) ? -uq : uq;
        sr = a[WIDTH-1] ? -ur : ur;
        res_hi = '0;
        res_lo = '0;
        case (op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV:   begin res_hi = sr; res_lo = sq; end
            OP_DIVU:  begin res_hi = ur; res_lo = uq; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush)      state_next = IDLE;
        else if (start) state_next = RUN;
        else if (done)  state_next = IDLE;
    end

    always_comb begin
        busy  = (state == RUN);
        stall = busy || (is_md && !flush);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_dz <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else if (flush) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_dz <= 1'b0;
        end else if (start) begin
            cnt     <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_dz <= is_div && b_zero;
        end else if (state == RUN) begin
            cnt <= cnt - CNT_W'(1);
            if (done && !pend_dz) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end else if (op == OP_MTHI) begin
            hi <= a;
        end else if (op == OP_MTLO) begin
            lo <= a;
        end
    end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit for the pipelined core, sitting beside the execute-stage ALU. Holds the HI/LO result registers. Accepts MULT/MULTU/DIV/DIVU with configurable latency and MTHI/MTLO single-cycle writes. Exposes `busy` and a combinational `stall` so decode can hold dependent instructions, in the same way the core stalls on register hazards.

## Interface
- `WIDTH`, 32, operand and HI/LO width.
- `MULT_CYCLES`, 5, multiply latency in cycles (≥1).
- `DIV_CYCLES`, 10, divide latency in cycles (≥1).
- `CNT_W`, 8, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `op`  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none).
- `a`  in  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO source).
- `b`  in  WIDTH  rt operand (divisor / multiplier).
- `flush`  in  1  abandon any in-flight operation.
- `busy`  out  1  operation in progress.
- `stall`  out  1  combinational: `busy`, or (`op` is 1..4 and not `flush`).
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- Reset values: `busy`=0, `hi`=0, `lo`=0, counter=0, pending HI/LO=0.
- Idle (`busy`=0) with `op` 1..4 at an edge:
  - Latch the result into pending registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Set `busy`=1.
- MULT: signed 2·WIDTH product. MULTU: unsigned product. Upper half goes to HI, lower half to LO.
- DIV: signed division, quotient truncated toward zero → LO, remainder (sign of dividend) → HI.
  - MIN/−1 wraps: LO=MIN, HI=0.
- DIVU: unsigned division, quotient → LO, remainder → HI.
- Divide by zero (DIV or DIVU):
  - Still busy for DIV_CYCLES.
  - HI/LO are left unchanged at completion.
- MTHI/MTLO while idle: `hi`/`lo` ← `a` at that edge; `busy` stays 0.
- Any `op` while `busy`=1 is ignored. The pipeline relies on `stall` to hold the instruction.
- `flush`=1 at an edge:
  - Clears `busy` and the counter.
  - Discards pending results; `hi`/`lo` keep their current values.
  - Any simultaneous `op` (including MTHI/MTLO) is ignored. Flush wins.
- Reserved op 7 and op 0 have no effect.

## Timing
- State machine: IDLE, RUN.
- IDLE→RUN on an accepted start at edge k.
- RUN: counter decrements each edge. At edge k+N (N = latency):
  - `hi`/`lo` ← pending values (unless divide-by-zero).
  - `busy` ← 0, return to IDLE.
- `busy` is high for exactly N cycles. New `hi`/`lo` are visible from the cycle after edge k+N, in the same cycle `busy` first reads 0.
- A new start is accepted at edge k+N+1 at the earliest. There is no back-to-back issue at the completion edge, because `busy` is still 1 when that edge is sampled.
- `stall` is high in the start cycle and throughout RUN, so a following MFHI/MFLO or mult/div is held until results are valid.
- Asynchronous reset mid-RUN: immediate return to IDLE with all outputs 0. No result is written after reset deasserts.
- N=1: `busy` high for one cycle; results appear at edge k+1.
- MTHI/MTLO take effect at the edge they are presented; readable in the next cycle.

## Test plan
- Reset, then MULT a=0xFFFFFFFF, b=0x00000002 at edge 0 → `busy`=1 for 5 cycles; after edge 5, hi=0xFFFFFFFF, lo=0xFFFFFFFE, busy=0.
- MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE after 5 cycles. MULTU 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI a=0x12345678, then DIVU a=7, b=0 → busy for 10 cycles; hi stays 0x12345678, lo unchanged. MTLO presented during busy is ignored.
- MULT started, `flush` at cycle 3 → busy=0 the next cycle; hi/lo keep prior values. Flush asserted together with a start → no operation begins.
- DIVU 100/7 in flight, async reset pulse at cycle 4 → hi=lo=0, busy=0 immediately; no late write after deassertion. Then MULTU 3×4 → lo=12 with `stall` high during the start cycle.
